// File: rtl/wiener_pkg.sv
// Shared state encoding, stats width and address-width helper for the
// Wiener block scheduler.
package wiener_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned STATS_W = 2 * DATA_W;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_STATS,
    LOAD,
    STREAM,
    DRAIN,
    DONE
  } sched_state_t;

  function automatic int unsigned addr_w(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/wiener_block_scheduler_if.sv
// Scheduler-side bus: frame control, stats handshake, calculator load,
// block buffer read and status. Perf counters exist only with WIENER_SCHED_PERF_EN.
interface wiener_block_scheduler_if #(
  parameter int unsigned DATA_WIDTH    = wiener_pkg::DATA_W,
  parameter int unsigned TOTAL_SAMPLES = 64
) ();

  localparam int unsigned SW = 2 * DATA_WIDTH;
  localparam int unsigned AW = wiener_pkg::addr_w(TOTAL_SAMPLES);

  logic          start_frame;
  logic [31:0]   blocks_per_frame;
  logic [SW-1:0] noise_variance_in;
  logic          stats_valid;
  logic          stats_accept;
  logic [SW-1:0] mean_in;
  logic [SW-1:0] variance_in;
  logic          calc_stats_ready;
  logic [SW-1:0] calc_mean;
  logic [SW-1:0] calc_variance;
  logic [SW-1:0] calc_noise_variance;
  logic          pix_rd_en;
  logic [AW-1:0] pix_rd_addr;
  logic          out_valid;
  logic [31:0]   block_idx;
  logic          busy;
  logic          frame_done;
`ifdef WIENER_SCHED_PERF_EN
  logic [31:0]   frame_cycles;
  logic [31:0]   stall_cycles;

  modport master (
    input  start_frame, blocks_per_frame, noise_variance_in, stats_valid, mean_in, variance_in,
    output stats_accept, calc_stats_ready, calc_mean, calc_variance, calc_noise_variance,
    output pix_rd_en, pix_rd_addr, out_valid, block_idx, busy, frame_done,
    output frame_cycles, stall_cycles
  );
  modport slave (
    output start_frame, blocks_per_frame, noise_variance_in, stats_valid, mean_in, variance_in,
    input  stats_accept, calc_stats_ready, calc_mean, calc_variance, calc_noise_variance,
    input  pix_rd_en, pix_rd_addr, out_valid, block_idx, busy, frame_done,
    input  frame_cycles, stall_cycles
  );
`else
  modport master (
    input  start_frame, blocks_per_frame, noise_variance_in, stats_valid, mean_in, variance_in,
    output stats_accept, calc_stats_ready, calc_mean, calc_variance, calc_noise_variance,
    output pix_rd_en, pix_rd_addr, out_valid, block_idx, busy, frame_done
  );
  modport slave (
    output start_frame, blocks_per_frame, noise_variance_in, stats_valid, mean_in, variance_in,
    input  stats_accept, calc_stats_ready, calc_mean, calc_variance, calc_noise_variance,
    input  pix_rd_en, pix_rd_addr, out_valid, block_idx, busy, frame_done
  );
`endif

endinterface

// File: rtl/valid_delay_line.sv
// Shift register aligning out_valid with calculator data_out
// (buffer read latency plus calculator latency).
module valid_delay_line #(
  parameter int unsigned DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/wiener_block_scheduler.sv
// Block-by-block sequencer for the Wiener filter datapath.
// Optional WIENER_SCHED_PERF_EN adds frame_cycles / stall_cycles counters.
module wiener_block_scheduler
  import wiener_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DATA_W,
  parameter int unsigned TOTAL_SAMPLES = 64,
  parameter int unsigned CALC_LATENCY  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  wiener_block_scheduler_if.master  bus
);

  localparam int unsigned SW = 2 * DATA_WIDTH;
  localparam int unsigned AW = addr_w(TOTAL_SAMPLES);
  localparam int unsigned DW = addr_w(CALC_LATENCY + 2);

  sched_state_t  state, state_nxt;
  logic [AW-1:0] smp_cnt;
  logic [DW-1:0] drn_cnt;
  logic [31:0]   blk_total;
  logic [31:0]   blk_idx;
  logic [SW-1:0] mean_q, var_q, noise_q;
  logic          start_ok, last_smp, drain_end, last_blk;

  assign start_ok  = (state == IDLE) && bus.start_frame;
  assign last_smp  = (smp_cnt == AW'(TOTAL_SAMPLES - 1));
  assign drain_end = (drn_cnt == DW'(CALC_LATENCY));
  assign last_blk  = (blk_idx == blk_total - 32'd1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and Moore-decoded control outputs
  always_comb begin
    state_nxt            = state;
    bus.stats_accept     = 1'b0;
    bus.calc_stats_ready = 1'b0;
    bus.pix_rd_en        = 1'b0;
    bus.pix_rd_addr      = '0;
    bus.frame_done       = 1'b0;
    bus.busy             = (state != IDLE);
    case (state)
      IDLE: begin
        if (bus.start_frame) state_nxt = (bus.blocks_per_frame == '0) ? DONE : WAIT_STATS;
      end
      WAIT_STATS: begin
        bus.stats_accept = 1'b1;
        if (bus.stats_valid) state_nxt = LOAD;
      end
      LOAD: begin
        bus.calc_stats_ready = 1'b1;
        state_nxt            = STREAM;
      end
      STREAM: begin
        bus.pix_rd_en   = 1'b1;
        bus.pix_rd_addr = smp_cnt;
        if (last_smp) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_end) state_nxt = last_blk ? DONE : WAIT_STATS;
      end
      DONE: begin
        bus.frame_done = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame/block latches and the sample / drain counters
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_total <= '0;
      blk_idx   <= '0;
      noise_q   <= '0;
      mean_q    <= '0;
      var_q     <= '0;
      smp_cnt   <= '0;
      drn_cnt   <= '0;
    end else begin
      if (start_ok && (bus.blocks_per_frame != '0)) begin
        blk_total <= bus.blocks_per_frame;
        noise_q   <= bus.noise_variance_in;
        blk_idx   <= '0;
      end
      if ((state == WAIT_STATS) && bus.stats_valid) begin
        mean_q <= bus.mean_in;
        var_q  <= bus.variance_in;
      end
      if (state == STREAM) smp_cnt <= last_smp ? '0 : smp_cnt + AW'(1);
      if (state == DRAIN) begin
        drn_cnt <= drain_end ? '0 : drn_cnt + DW'(1);
        if (drain_end && !last_blk) blk_idx <= blk_idx + 32'd1;
      end
    end
  end

  assign bus.calc_mean           = mean_q;
  assign bus.calc_variance       = var_q;
  assign bus.calc_noise_variance = noise_q;
  assign bus.block_idx           = blk_idx;

  valid_delay_line #(.DEPTH(1 + CALC_LATENCY)) u_valid_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.pix_rd_en),
    .dout (bus.out_valid)
  );

`ifdef WIENER_SCHED_PERF_EN
  logic [31:0] frame_cyc_q, stall_cyc_q;

  // Saturating activity counters, cleared when a frame is started
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cyc_q <= '0;
      stall_cyc_q <= '0;
    end else if (start_ok) begin
      frame_cyc_q <= '0;
      stall_cyc_q <= '0;
    end else begin
      if ((state != IDLE) && (frame_cyc_q != '1)) frame_cyc_q <= frame_cyc_q + 32'd1;
      if ((state == WAIT_STATS) && (stall_cyc_q != '1)) stall_cyc_q <= stall_cyc_q + 32'd1;
    end
  end

  assign bus.frame_cycles = frame_cyc_q;
  assign bus.stall_cycles = stall_cyc_q;
`endif

endmodule

// File: tb/tb_wiener_block_scheduler.sv
// Scoreboard bench for wiener_block_scheduler (TOTAL_SAMPLES=8, CALC_LATENCY=2);
// also covers the WIENER_SCHED_PERF_EN counters when that macro is defined.
module tb_wiener_block_scheduler;
  import wiener_pkg::*;

  localparam int unsigned TS = 8;
  localparam int unsigned CL = 2;

  typedef struct {
    logic [STATS_W-1:0] mean;
    logic [STATS_W-1:0] variance;
    logic [STATS_W-1:0] noise;
    int                 blk;
  } load_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wiener_block_scheduler_if #(.DATA_WIDTH(DATA_W), .TOTAL_SAMPLES(TS)) bus ();

  wiener_block_scheduler #(.DATA_WIDTH(DATA_W), .TOTAL_SAMPLES(TS), .CALC_LATENCY(CL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  logic [STATS_W-1:0] cur_noise = '0;

  load_exp_t exp_load[$];
  int        exp_done[$];
  load_exp_t e;

  int ld_cnt, rd_cnt, ov_cnt, done_cnt, busy_cnt, acc_cnt;
  int ld_first, rd_first, rd_last, ov_first, ov_last, busy_first, busy_last;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc - t0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_logs();
    ld_cnt = 0; rd_cnt = 0; ov_cnt = 0; done_cnt = 0; busy_cnt = 0; acc_cnt = 0;
    ld_first = -1; rd_first = -1; rd_last = -1; ov_first = -1; ov_last = -1;
    busy_first = -1; busy_last = -1;
  endtask

  task automatic chk_all_zero(input string tag);
    logic any;
    any = bus.stats_accept | bus.calc_stats_ready | (|bus.calc_mean) | (|bus.calc_variance) |
          (|bus.calc_noise_variance) | bus.pix_rd_en | (|bus.pix_rd_addr) | bus.out_valid |
          (|bus.block_idx) | bus.busy | bus.frame_done;
`ifdef WIENER_SCHED_PERF_EN
    any = any | (|bus.frame_cycles) | (|bus.stall_cycles);
`endif
    chk(tag, 64'(any), 64'd0);
  endtask

  // Monitor: logs output activity and pops the scoreboards
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.calc_stats_ready) begin
      ld_cnt++;
      if (ld_first < 0) ld_first = cyc;
      if (exp_load.size() == 0) chk("load_unexpected", 64'd1, 64'd0);
      else begin
        e = exp_load.pop_front();
        chk("calc_mean", 64'(bus.calc_mean), 64'(e.mean));
        chk("calc_variance", 64'(bus.calc_variance), 64'(e.variance));
        chk("calc_noise", 64'(bus.calc_noise_variance), 64'(e.noise));
        chk("block_idx", 64'(bus.block_idx), 64'(e.blk));
      end
    end
    if (bus.pix_rd_en) begin
      chk("rd_addr", 64'(bus.pix_rd_addr), 64'(rd_cnt % TS));
      rd_cnt++;
      if (rd_first < 0) rd_first = cyc;
      rd_last = cyc;
    end
    if (bus.out_valid) begin
      ov_cnt++;
      if (ov_first < 0) ov_first = cyc;
      ov_last = cyc;
    end
    if (bus.busy) begin
      busy_cnt++;
      if (busy_first < 0) busy_first = cyc;
      busy_last = cyc;
    end
    if (bus.stats_accept) acc_cnt++;
    if (bus.frame_done) begin
      done_cnt++;
      if (exp_done.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
      else chk("done_cycle", 64'(cyc - t0), 64'(exp_done.pop_front() - t0));
    end
  end

  // Drives start in the current cycle (cycle 0) and returns in cycle 1.
  task automatic begin_frame(input int bpf, input logic [STATS_W-1:0] noise, input int done_rel);
    clear_logs();
    t0 = cyc;
    cur_noise = noise;
    bus.start_frame = 1'b1;
    bus.blocks_per_frame = bpf;
    bus.noise_variance_in = noise;
    if (done_rel >= 0) exp_done.push_back(cyc + done_rel);
    tick();
    bus.start_frame = 1'b0;
    bus.blocks_per_frame = 32'hffff_ffff;
    bus.noise_variance_in = 16'hbeef;
  endtask

  task automatic give_stats(input int blk, input int dly, input logic [STATS_W-1:0] m,
                            input logic [STATS_W-1:0] v, input bit hold);
    int n;
    n = 0;
    while (!bus.stats_accept && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("accept_timeout", 64'd0, 64'd1);
    repeat (dly) tick();
    bus.stats_valid = 1'b1;
    bus.mean_in = m;
    bus.variance_in = v;
    exp_load.push_back('{m, v, cur_noise, blk});
    tick();
    if (hold) begin
      bus.mean_in = 16'h0999;
      bus.variance_in = 16'h0888;
    end else begin
      bus.stats_valid = 1'b0;
    end
  endtask

  task automatic run_to(input int rel);
    while (cyc - t0 < rel) tick();
  endtask

  task automatic end_checks(input string tag);
    chk({tag, "_idle"}, 64'(bus.busy), 64'd0);
    chk({tag, "_done_pending"}, 64'(exp_done.size()), 64'd0);
    chk({tag, "_load_pending"}, 64'(exp_load.size()), 64'd0);
    exp_done.delete();
    exp_load.delete();
  endtask

  initial begin
    bus.start_frame = 1'b0;
    bus.blocks_per_frame = '0;
    bus.noise_variance_in = '0;
    bus.stats_valid = 1'b0;
    bus.mean_in = '0;
    bus.variance_in = '0;
    clear_logs();
    repeat (3) tick();
    chk_all_zero("reset_outputs");
    rst = 1'b0;
    tick();
    chk_all_zero("idle_outputs");

    // Single block, stats in cycle 1
    tick();
    begin_frame(1, 16'h0020, 14);
    give_stats(0, 0, 16'h0080, 16'h0040, 1'b0);
    run_to(20);
    chk("t1_load_cycle", 64'(ld_first - t0), 64'd2);
    chk("t1_load_cnt", 64'(ld_cnt), 64'd1);
    chk("t1_rd_first", 64'(rd_first - t0), 64'd3);
    chk("t1_rd_last", 64'(rd_last - t0), 64'd10);
    chk("t1_rd_cnt", 64'(rd_cnt), 64'd8);
    chk("t1_ov_first", 64'(ov_first - t0), 64'd6);
    chk("t1_ov_last", 64'(ov_last - t0), 64'd13);
    chk("t1_ov_cnt", 64'(ov_cnt), 64'd8);
    chk("t1_busy_first", 64'(busy_first - t0), 64'd1);
    chk("t1_busy_last", 64'(busy_last - t0), 64'd14);
    chk("t1_busy_cnt", 64'(busy_cnt), 64'd14);
    chk("t1_done_cnt", 64'(done_cnt), 64'd1);
    end_checks("t1");

    // Three blocks, stats 5 cycles late each
    tick();
    begin_frame(3, 16'h0030, 55);
    for (int b = 0; b < 3; b++) give_stats(b, 5, 16'(16'h0100 + b), 16'(16'h0200 + b), 1'b0);
    run_to(60);
    chk("t2_load_cnt", 64'(ld_cnt), 64'd3);
    chk("t2_rd_cnt", 64'(rd_cnt), 64'd24);
    chk("t2_ov_cnt", 64'(ov_cnt), 64'd24);
    chk("t2_done_cnt", 64'(done_cnt), 64'd1);
    chk("t2_busy_last", 64'(busy_last - t0), 64'd55);
    end_checks("t2");

    // Empty frame
    tick();
    begin_frame(0, 16'h0040, 1);
    run_to(6);
    chk("t3_accept_cnt", 64'(acc_cnt), 64'd0);
    chk("t3_rd_cnt", 64'(rd_cnt), 64'd0);
    chk("t3_ov_cnt", 64'(ov_cnt), 64'd0);
    chk("t3_busy_cnt", 64'(busy_cnt), 64'd1);
    chk("t3_done_cnt", 64'(done_cnt), 64'd1);
    end_checks("t3");

    // Re-start while busy, stats_valid held high after the handshake
    tick();
    begin_frame(1, 16'h0050, 14);
    give_stats(0, 0, 16'h0111, 16'h0222, 1'b1);
    run_to(5);
    bus.start_frame = 1'b1;
    bus.blocks_per_frame = 32'd5;
    tick();
    bus.start_frame = 1'b0;
    run_to(14);
    chk("t4_calc_mean_held", 64'(bus.calc_mean), 64'h0111);
    bus.stats_valid = 1'b0;
    run_to(20);
    chk("t4_load_cnt", 64'(ld_cnt), 64'd1);
    chk("t4_rd_cnt", 64'(rd_cnt), 64'd8);
    chk("t4_ov_cnt", 64'(ov_cnt), 64'd8);
    chk("t4_done_cnt", 64'(done_cnt), 64'd1);
    end_checks("t4");

    // Reset mid-STREAM
    tick();
    begin_frame(1, 16'h0060, -1);
    give_stats(0, 0, 16'h0123, 16'h0456, 1'b0);
    run_to(8);
    rst = 1'b1;
    tick();
    chk_all_zero("t5_reset_outputs");
    rst = 1'b0;
    run_to(30);
    chk("t5_ov_last", 64'(ov_last - t0), 64'd8);
    chk("t5_rd_last", 64'(rd_last - t0), 64'd8);
    chk("t5_done_cnt", 64'(done_cnt), 64'd0);
    end_checks("t5");

`ifdef WIENER_SCHED_PERF_EN
    // Perf counters, stats 3 cycles late
    tick();
    begin_frame(1, 16'h0070, 17);
    give_stats(0, 3, 16'h0033, 16'h0044, 1'b0);
    run_to(22);
    chk("perf_frame_cycles", 64'(bus.frame_cycles), 64'd17);
    chk("perf_stall_cycles", 64'(bus.stall_cycles), 64'd4);
    end_checks("perf");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
